// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake on both sides.
// It adds flush (a bubble that drops held beats), hold (freezes the stage),
// and a saturating stall counter.
// Build option PIPE_STAGE_SKID_EN: when it is defined, a skid entry is added.
// The stage then holds two beats and in_ready no longer depends on out_ready.
// When it is undefined, the stage holds one beat and in_ready depends
// combinationally on out_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              hold,
  input  logic              stall_cnt_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_p1, state_nxt;
  logic [DATA_W-1:0]   data_p1;
  logic [CTRL_W-1:0]   ctrl_p1;
  logic [CNT_W-1:0]    stall_p1;
  logic                in_xfer, out_xfer, load_head;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0]   skid_data_p1;
  logic [CTRL_W-1:0]   skid_ctrl_p1;
  logic                load_skid, skid_to_head;
`endif

  // Saturating increment: the counter sticks at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready  = (state_p1 != TWO) && !hold && !flush && !rst;
`else
  assign in_ready  = ((state_p1 == EMPTY) || out_ready) && !hold && !flush && !rst;
`endif
  // rst also gates out_valid, so no beat transfers out in a reset cycle.
  assign out_valid = (state_p1 != EMPTY) && !hold && !rst;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign occupancy = state_p1;
  assign out_data  = data_p1;
  assign out_ctrl  = ctrl_p1;
  assign stall_cnt = stall_p1;

  // Next occupancy state and storage write enables.
  always_comb begin
    state_nxt = state_p1;
    load_head = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid    = 1'b0;
    skid_to_head = 1'b0;
`endif
    case (state_p1)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_head = 1'b1;
        end else if (in_xfer) begin
`ifdef PIPE_STAGE_SKID_EN
          state_nxt = TWO;
          load_skid = 1'b1;
`endif
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      TWO: begin
        if (out_xfer) begin
          state_nxt    = ONE;
          skid_to_head = 1'b1;
        end
      end
`endif
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_p1 <= EMPTY;
    else     state_p1 <= state_nxt;
  end

  // ---- stage p1: head entry. It keeps its last value while the stage is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      ctrl_p1 <= '0;
    end else if (flush) begin
      ctrl_p1 <= '0;
    end else if (load_head) begin
      data_p1 <= in_data;
      ctrl_p1 <= in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
    end else if (skid_to_head) begin
      data_p1 <= skid_data_p1;
      ctrl_p1 <= skid_ctrl_p1;
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid entry: catches a beat that is accepted while the head is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data_p1 <= '0;
      skid_ctrl_p1 <= '0;
    end else if (flush) begin
      skid_ctrl_p1 <= '0;
    end else if (load_skid) begin
      skid_data_p1 <= in_data;
      skid_ctrl_p1 <= in_ctrl;
    end
  end
`endif

  // Stall counter: counts blocked upstream cycles. A clear wins over an increment.
  always_ff @(posedge clk) begin
    if (rst)                        stall_p1 <= '0;
    else if (stall_cnt_clr)         stall_p1 <= '0;
    else if (in_valid && !in_ready) stall_p1 <= sat_inc(stall_p1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg using directed vectors and a scoreboard queue.
// The DUT is built with CNT_W=2 so that stall counter saturation is reachable.
module tb_pipe_stage_reg;
  localparam int DATA_W = 16;
  localparam int CTRL_W = 6;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, out_valid, out_ready;
  logic              flush, hold, stall_cnt_clr;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  logic [DATA_W+CTRL_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .hold(hold), .stall_cnt_clr(stall_cnt_clr),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    exp_q.push_back({d, c});
  endtask

  // Monitor: every output transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual data=0x%0h ctrl=0x%0h required=no beat", out_data, out_ctrl);
      end else begin
        logic [DATA_W+CTRL_W-1:0] e;
        e = exp_q.pop_front();
        if ({out_data, out_ctrl} !== e) begin
          errors++;
          $display("FAIL sb_beat actual data=0x%0h ctrl=0x%0h required data=0x%0h ctrl=0x%0h",
                   out_data, out_ctrl, e[DATA_W+CTRL_W-1:CTRL_W], e[CTRL_W-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    flush = 1'b0; hold = 1'b0; stall_cnt_clr = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("in_ready_in_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("in_ready_after_rst", in_ready, 1);

    // Single beat, one cycle of latency.
    out_ready = 1'b1;
    push(16'h1234, 6'b000011);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 16'h1234);
    chk("t1_ctrl", out_ctrl, 6'b000011);
    chk("t1_occ", occupancy, 1);
    cyc();
    @(negedge clk);
    chk("t1_empty_occ", occupancy, 0);
    chk("t1_hold_data", out_data, 16'h1234);
    chk("t1_hold_ctrl", out_ctrl, 6'b000011);

    // Back-to-back stream with no gaps.
    for (int i = 1; i <= 8; i++) begin
      push(DATA_W'(i), CTRL_W'(i));
      cyc();
      @(negedge clk);
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, i);
    end
    in_valid = 1'b0;
    cyc();

    // Output back-pressure.
    out_ready = 1'b0;
    push(16'hAAAA, 6'h01);
    cyc();
`ifdef PIPE_STAGE_SKID_EN
    push(16'hBBBB, 6'h02);
    cyc();
    in_valid = 1'b1; in_data = 16'hCCCC; in_ctrl = 6'h03;
    @(negedge clk);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_occ", occupancy, 2);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_stall", stall_cnt, 1);
    out_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("t3_occ_drained", occupancy, 0);
    chk("t3_last", out_data, 16'hBBBB);
`else
    in_valid = 1'b1; in_data = 16'hBBBB; in_ctrl = 6'h02;
    @(negedge clk);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_occ", occupancy, 1);
    cyc();
    @(negedge clk);
    chk("t3_stall", stall_cnt, 1);
    chk("t3_occ_still", occupancy, 1);
    out_ready = 1'b1;
    exp_q.push_back({16'hBBBB, 6'h02});
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_second", out_data, 16'hBBBB);
    cyc();
`endif
    @(negedge clk);
    chk("t3_stall_kept", stall_cnt, 1);

    // A flush together with an incoming beat drops both beats.
    out_ready = 1'b0;
    push(16'h5555, 6'h21);
    cyc();
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h6666; in_ctrl = 6'h3F;
    @(negedge clk);
    chk("t4_in_ready", in_ready, 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_valid", out_valid, 0);
    chk("t4_ctrl", out_ctrl, 0);
    chk("t4_occ", occupancy, 0);
    chk("t4_stall_not_cleared", stall_cnt, 2);
    out_ready = 1'b1;
    cyc(); cyc();

    // Hold freezes the stage, and the stall counter saturates and then clears.
    out_ready = 1'b0;
    push(16'h7777, 6'h05);
    cyc();
    hold = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h8888; in_ctrl = 6'h06;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_valid", out_valid, 0);
      chk("t5_in_ready", in_ready, 0);
      chk("t5_data", out_data, 16'h7777);
      chk("t5_ctrl", out_ctrl, 6'h05);
      cyc();
    end
    @(negedge clk);
    chk("t5_stall_sat", stall_cnt, 3);
    chk("t5_occ", occupancy, 1);
    stall_cnt_clr = 1'b1;
    cyc();
    @(negedge clk);
    chk("t5_stall_clr", stall_cnt, 0);
    stall_cnt_clr = 1'b0; hold = 1'b0; in_valid = 1'b0;
    cyc(); cyc();

    // Reset while the stage is occupied.
    out_ready = 1'b0;
    push(16'h9999, 6'h11);
    cyc();
`ifdef PIPE_STAGE_SKID_EN
    push(16'hA0A0, 6'h12);
    cyc();
    @(negedge clk);
    chk("t6_occ_full", occupancy, 2);
`endif
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_rst", in_ready, 0);
    cyc();
    exp_q.delete();
    @(negedge clk);
    chk("t6_occ", occupancy, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_ctrl", out_ctrl, 0);
    chk("t6_stall", stall_cnt, 0);
    chk("t6_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_in_ready_release", in_ready, 1);

    cyc();
    chk("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
